// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result bus between operand registers and the sequential ALU
interface alu_seq_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             e;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] y;
  logic             ack;
  logic             busy;
  logic             zf;
  logic             nf;
  logic             cf;
  logic             vf;
  logic             err;
  modport master (output a, b, e, opcode, input y, ack, busy, zf, nf, cf, vf, err);
  modport slave  (input a, b, e, opcode, output y, ack, busy, zf, nf, cf, vf, err);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/ack handshake, status flags and iterative shift-add multiplier
module alu_seq #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t             r_state;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [SHW:0]       r_cnt;
  logic               r_ack;
  logic               r_busy;
  logic               r_cf;
  logic               r_vf;
  logic               r_err;
  logic [WIDTH-1:0]   w_y;
  logic               w_cf;
  logic               w_vf;
  logic               w_err;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH:0]     w_sra;
  logic [2*WIDTH-1:0] w_prod;
  assign w_sh   = bus.b[SHW-1:0];
  assign w_add  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_sub  = {1'b0, bus.a} - {1'b0, bus.b};
  assign w_shl  = {1'b0, bus.a} << w_sh;
  assign w_shr  = {bus.a, 1'b0} >> w_sh;
  assign w_sra  = $signed({bus.a, 1'b0}) >>> w_sh;
  assign w_prod = r_prod + (r_mplier[0] ? r_mcand : '0);
  // single-cycle result and flags for every non-multiply opcode
  always_comb begin
    w_y   = '0;
    w_cf  = 1'b0;
    w_vf  = 1'b0;
    w_err = 1'b0;
    case (bus.opcode)
      4'h0: begin
        w_y  = w_add[WIDTH-1:0];
        w_cf = w_add[WIDTH];
        w_vf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_add[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'h1: begin
        w_y  = w_sub[WIDTH-1:0];
        w_cf = w_sub[WIDTH];
        w_vf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_sub[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'h2: w_y = bus.a & bus.b;
      4'h3: w_y = bus.a | bus.b;
      4'h4: w_y = bus.a ^ bus.b;
      4'h5: w_y = ~bus.a;
      4'h6: begin
        w_y  = w_shl[WIDTH-1:0];
        w_cf = w_shl[WIDTH];
      end
      4'h7: begin
        w_y  = w_shr[WIDTH:1];
        w_cf = w_shr[0];
      end
      4'h8: w_y = '0;
      4'h9: begin
        w_y  = w_sra[WIDTH:1];
        w_cf = w_sra[0];
      end
      4'hA: w_y = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      4'hB: w_y = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      default: w_err = 1'b1;
    endcase
  end
  // handshake FSM: single-cycle ops complete from IDLE, multiply iterates one bit per cycle in MUL
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_y      <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
      r_cf     <= 1'b0;
      r_vf     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.e && bus.opcode == 4'h8) begin
          r_mcand  <= {{WIDTH{1'b0}}, bus.a};
          r_mplier <= bus.b;
          r_prod   <= '0;
          r_cnt    <= (SHW+1)'(WIDTH);
          r_busy   <= 1'b1;
          r_state  <= MUL;
        end else if (bus.e) begin
          r_y   <= w_y;
          r_cf  <= w_cf;
          r_vf  <= w_vf;
          r_err <= w_err;
          r_ack <= 1'b1;
        end
      end else begin
        r_prod   <= w_prod;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - 1'b1;
        if (r_cnt == (SHW+1)'(1)) begin
          r_y     <= w_prod[WIDTH-1:0];
          r_cf    <= |w_prod[2*WIDTH-1:WIDTH];
          r_vf    <= 1'b0;
          r_err   <= 1'b0;
          r_ack   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      end
    end
  end
  assign bus.y    = r_y;
  assign bus.ack  = r_ack;
  assign bus.busy = r_busy;
  assign bus.zf   = ~|r_y;
  assign bus.nf   = r_y[WIDTH-1];
  assign bus.cf   = r_cf;
  assign bus.vf   = r_vf;
  assign bus.err  = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  alu_seq_if #(.WIDTH(32)) s ();
  alu_seq_if #(.WIDTH(8))  s8 ();
  alu_seq #(.WIDTH(32)) dut   (.clk(clk), .rst(rst), .bus(s));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(s8));
  typedef struct packed {
    logic [31:0] y;
    logic        cf;
    logic        vf;
    logic        err;
  } res_t;
  function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sb, sr;
    int sh;
    logic [63:0] p;
    r = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    case (op)
      4'd0: begin p = 64'(a) + 64'(b); r.y = p[31:0]; r.cf = p[32]; sr = sa + sb; r.vf = sr != longint'($signed(r.y)); end
      4'd1: begin r.y = a - b; r.cf = a < b; sr = sa - sb; r.vf = sr != longint'($signed(r.y)); end
      4'd2: r.y = a & b;
      4'd3: r.y = a | b;
      4'd4: r.y = a ^ b;
      4'd5: r.y = ~a;
      4'd6: begin r.y = a << sh; r.cf = (sh == 0) ? 1'b0 : a[32-sh]; end
      4'd7: begin r.y = a >> sh; r.cf = (sh == 0) ? 1'b0 : a[sh-1]; end
      4'd8: begin p = 64'(a) * 64'(b); r.y = p[31:0]; r.cf = |p[63:32]; end
      4'd9: begin r.y = $signed(a) >>> sh; r.cf = (sh == 0) ? 1'b0 : a[sh-1]; end
      4'd10: r.y = {31'b0, sa < sb};
      4'd11: r.y = {31'b0, a < b};
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_res(input string tag, input res_t m);
    chk({tag, ".y"}, s.y, m.y);
    chk({tag, ".cf"}, s.cf, m.cf);
    chk({tag, ".vf"}, s.vf, m.vf);
    chk({tag, ".err"}, s.err, m.err);
    chk({tag, ".zf"}, s.zf, m.y == 32'd0);
    chk({tag, ".nf"}, s.nf, m.y[31]);
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    s.a = a; s.b = b; s.opcode = op; s.e = 1'b1;
    @(posedge clk); #1;
    s.e = 1'b0;
  endtask
  task automatic chk_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    chk($sformatf("op%0h.ack", op), s.ack, 1'b1);
    chk_res($sformatf("op%0h", op), model(op, a, b));
  endtask
  task automatic dir(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ey, input logic ecf, input logic evf);
    chk_op(op, a, b);
    chk($sformatf("dir%0h.y", op), s.y, ey);
    chk($sformatf("dir%0h.cf", op), s.cf, ecf);
    chk($sformatf("dir%0h.vf", op), s.vf, evf);
  endtask
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] prev;
    int n;
    prev = s.y;
    issue(4'd8, a, b);
    n = 1;
    chk("mul.busy_start", s.busy, 1'b1);
    chk("mul.noack_start", s.ack, 1'b0);
    while (!s.ack && n < 100) begin
      @(negedge clk);
      s.e = (n % 3 == 0);
      s.opcode = 4'd0;
      s.a = $urandom; s.b = $urandom;
      @(posedge clk); #1;
      s.e = 1'b0;
      n++;
      if (!s.ack) begin
        chk("mul.hold_y", s.y, prev);
        chk("mul.busy", s.busy, 1'b1);
      end
    end
    chk("mul.latency", n, 33);
    chk("mul.busy_end", s.busy, 1'b0);
    chk_res("mul", model(4'd8, a, b));
    @(posedge clk); #1;
    chk("mul.ack_once", s.ack, 1'b0);
  endtask
  initial begin
    int n, acks;
    s.a = '0; s.b = '0; s.e = 1'b0; s.opcode = '0;
    s8.a = '0; s8.b = '0; s8.e = 1'b0; s8.opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.y", s.y, 0);
    chk("rst.ack", s.ack, 0);
    chk("rst.busy", s.busy, 0);
    chk("rst.flags", {s.cf, s.vf, s.err, s.nf}, 0);
    chk("rst.zf", s.zf, 1'b1);
    chk("rst8.y", s8.y, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("idle.ack", s.ack, 0);
    dir(4'd0, 8, 6, 14, 0, 0);
    dir(4'd1, 8, 6, 2, 0, 0);
    dir(4'd2, 8, 6, 0, 0, 0);
    chk("and.zf", s.zf, 1'b1);
    dir(4'd3, 8, 6, 14, 0, 0);
    dir(4'd4, 8, 6, 14, 0, 0);
    dir(4'd5, 8, 6, 32'hFFFFFFF7, 0, 0);
    chk("not.nf", s.nf, 1'b1);
    dir(4'd6, 8, 6, 512, 0, 0);
    dir(4'd7, 8, 6, 0, 0, 0);
    @(posedge clk); #1;
    chk("ack.pulse", s.ack, 0);
    chk("y.hold", s.y, 0);
    do_mul(8, 6);
    chk("mul86.y", s.y, 48);
    dir(4'd0, 32'hFFFFFFFF, 1, 0, 1, 0);
    chk("addwrap.zf", s.zf, 1'b1);
    dir(4'd0, 32'h7FFFFFFF, 1, 32'h80000000, 0, 1);
    chk("addovf.nf", s.nf, 1'b1);
    dir(4'd1, 6, 8, 32'hFFFFFFFE, 1, 0);
    dir(4'd10, 32'hFFFFFFFF, 1, 1, 0, 0);
    dir(4'd11, 32'hFFFFFFFF, 1, 0, 0, 0);
    dir(4'd15, 8, 6, 0, 0, 0);
    chk("illegal.err", s.err, 1'b1);
    do_mul(32'h80000000, 2);
    chk("mulovf.y", s.y, 0);
    chk("mulovf.cf", s.cf, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s.a = $urandom; s.b = $urandom; s.opcode = 4'(i); s.e = 1'b1;
      @(posedge clk); #1;
      chk("b2b.ack", s.ack, 1'b1);
      chk_res("b2b", model(4'(i), s.a, s.b));
    end
    s.e = 1'b0;
    issue(4'd8, 32'h1234, 32'h5678);
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.busy", s.busy, 0);
    chk("abort.ack", s.ack, 0);
    chk("abort.y", s.y, 0);
    acks = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (s.ack) acks++;
    end
    chk("abort.noack", acks, 0);
    chk_op(4'd0, 100, 23);
    chk("after_abort.y", s.y, 123);
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      if (i % 4 == 0) b = b & 32'h1F;
      if (op == 4'd8) do_mul(a, b);
      else chk_op(op, a, b);
    end
    @(negedge clk);
    s8.a = 8'hFF; s8.b = 8'hFF; s8.opcode = 4'd8; s8.e = 1'b1;
    @(posedge clk); #1;
    s8.e = 1'b0;
    n = 1;
    while (!s8.ack && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w8.latency", n, 9);
    chk("w8.y", s8.y, 8'h01);
    chk("w8.cf", s8.cf, 1'b1);
    chk("w8.busy", s8.busy, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
